axi_rw_bridge: RTL
==================

AXI_RW_BRIDGE -- requirements
Module: axi_rw_bridge

Interface
REQ-001 SHALL take parameter ADDR_W, default 32, the AXI address width.
REQ-002 SHALL take parameter DATA_W, default 64, the AXI data beat width (64 or 128).
REQ-003 SHALL take parameter LINE_W, default 128, the cache-line width; LINE_W = BEATS*DATA_W, BEATS = 1, 2, 4 or 8.
REQ-004 SHALL take parameter AXI_ID, default 4'd0, the constant driven on axi_ar_id_o and axi_aw_id_o.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port req_valid/req_ready, input/output, 1 bit each: request handshake.
REQ-008 SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port req_dev, input, 1 bit: 1 = uncached single-beat access, 0 = line burst.
REQ-010 SHALL have port req_addr, input, ADDR_W bits: byte address.
REQ-011 SHALL have port req_size, input, 3 bits: AXI size code for device accesses.
REQ-012 SHALL have port req_wdata, input, LINE_W bits: write line (device writes use bits DATA_W-1:0).
REQ-013 SHALL have port req_wstrb, input, DATA_W/8 bits: device-write byte strobe.
REQ-014 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port resp_rdata, output, LINE_W bits: read line.
REQ-016 SHALL have port resp_err, output, 1 bit: any non-OKAY response seen in the transaction.
REQ-017 SHALL have the AW channel: axi_aw_valid_o out 1, axi_aw_ready_i in 1, axi_aw_addr_o out ADDR_W, axi_aw_id_o out 4, axi_aw_len_o out 8, axi_aw_size_o out 3, axi_aw_burst_o out 2.
REQ-018 SHALL have the W channel: axi_w_valid_o out 1, axi_w_ready_i in 1, axi_w_data_o out DATA_W, axi_w_strb_o out DATA_W/8, axi_w_last_o out 1.
REQ-019 SHALL have the B channel: axi_b_valid_i in 1, axi_b_ready_o out 1, axi_b_resp_i in 2, axi_b_id_i in 4.
REQ-020 SHALL have the AR channel: axi_ar_valid_o out 1, axi_ar_ready_i in 1, axi_ar_addr_o out ADDR_W, axi_ar_id_o out 4, axi_ar_len_o out 8, axi_ar_size_o out 3, axi_ar_burst_o out 2.
REQ-021 SHALL have the R channel: axi_r_valid_i in 1, axi_r_ready_o out 1, axi_r_resp_i in 2, axi_r_data_i in DATA_W, axi_r_last_i in 1, axi_r_id_i in 4.

Function
REQ-022 SHALL implement FSM states IDLE, AR, R, AW, W, B, RESP; req_ready = 1 only in IDLE.
REQ-023 SHALL, on req_valid && req_ready, capture all req_* inputs and go to AR (read) or AW (write); AR/AW valid asserts the next cycle.
REQ-024 SHALL drive line accesses as burst INCR (2'b01), len BEATS-1, size log2(DATA_W/8), with the address aligned down to LINE_W/8.
REQ-025 SHALL drive device accesses as len 0, size req_size, with the unmodified address.
REQ-026 SHALL hold every *_valid_o and its payload stable until the matching ready; AR->R and AW->W happen on the handshake cycle.
REQ-027 SHALL, in R, hold axi_r_ready_o = 1 and write beat k to resp_rdata[k*DATA_W +: DATA_W]; the beat counter saturates at BEATS-1.
REQ-028 SHALL load device read data into beat 0 and zero the remaining bits.
REQ-029 SHALL leave R for RESP on the beat with axi_r_last_i = 1; rlast before the final beat sets resp_err.
REQ-030 SHALL, in W, send beat k = req_wdata[k*DATA_W +: DATA_W] with strb all-ones (line) or req_wstrb (device), and assert axi_w_last_o on beat BEATS-1 (line) or beat 0 (device).
REQ-031 SHALL go W->B after the last-beat handshake, hold axi_b_ready_o = 1 in B, and go B->RESP on axi_b_valid_i.
REQ-032 SHALL set resp_err sticky on any rresp/bresp != 2'b00, clear it on request acceptance, and ignore response IDs.
REQ-033 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; resp_rdata and resp_err hold until the next acceptance.
REQ-034 SHALL ignore AXI inputs that arrive while the bridge is outside the matching state.

Reset
REQ-035 SHALL, on rst, enter IDLE and clear all valid/ready outputs, resp_valid, resp_err, resp_rdata and the beat counter.
REQ-036 SHALL, on reset mid-transaction, abandon the transaction (no resp_valid) with all valids low the cycle after the reset edge.

Verification
REQ-037 Line read at 0x8000_0018, DATA_W=64, LINE_W=128 -> araddr 0x8000_0010, len 1, size 3, burst 1; beats A then B -> resp_rdata {B,A}, resp_err 0, one pulse.
REQ-038 Device write at 0xA000_0004, size 2, strb 8'hF0 -> awlen 0, awaddr unchanged, a single W beat with wlast=1 and strb 8'hF0; bresp 2'b10 -> resp_err 1.
REQ-039 Line write with arready/wready stalled 5 cycles -> valid and payload stable throughout, exactly 2 W beats, wlast only on the second.
REQ-040 Read where rlast arrives on beat 0 of 2 -> RESP entered, resp_err 1.
REQ-041 rst asserted while in W -> next cycle IDLE, req_ready 1, all AXI valids 0, no resp_valid.
REQ-042 Back-to-back requests with req_valid held -> second accepted exactly one cycle after the first resp_valid pulse.

Source files
------------

// File: rtl/axi_rw_bridge.sv
// Single-outstanding bridge from a line/device request port to AXI4 read and write channels.
// One transaction at a time; resp_valid pulses once per accepted request.
module axi_rw_bridge #(
  parameter int          ADDR_W = 32,
  parameter int          DATA_W = 64,
  parameter int          LINE_W = 128,
  parameter logic [3:0]  AXI_ID = 4'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_dev,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2:0]            req_size,
  input  logic [LINE_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  resp_valid,
  output logic [LINE_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  axi_aw_valid_o,
  input  logic                  axi_aw_ready_i,
  output logic [ADDR_W-1:0]     axi_aw_addr_o,
  output logic [3:0]            axi_aw_id_o,
  output logic [7:0]            axi_aw_len_o,
  output logic [2:0]            axi_aw_size_o,
  output logic [1:0]            axi_aw_burst_o,
  output logic                  axi_w_valid_o,
  input  logic                  axi_w_ready_i,
  output logic [DATA_W-1:0]     axi_w_data_o,
  output logic [DATA_W/8-1:0]   axi_w_strb_o,
  output logic                  axi_w_last_o,
  input  logic                  axi_b_valid_i,
  output logic                  axi_b_ready_o,
  input  logic [1:0]            axi_b_resp_i,
  input  logic [3:0]            axi_b_id_i,
  output logic                  axi_ar_valid_o,
  input  logic                  axi_ar_ready_i,
  output logic [ADDR_W-1:0]     axi_ar_addr_o,
  output logic [3:0]            axi_ar_id_o,
  output logic [7:0]            axi_ar_len_o,
  output logic [2:0]            axi_ar_size_o,
  output logic [1:0]            axi_ar_burst_o,
  input  logic                  axi_r_valid_i,
  output logic                  axi_r_ready_o,
  input  logic [1:0]            axi_r_resp_i,
  input  logic [DATA_W-1:0]     axi_r_data_i,
  input  logic                  axi_r_last_i,
  input  logic [3:0]            axi_r_id_i
);

  localparam int                BEATS      = LINE_W / DATA_W;
  localparam int                BW         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0]     LAST_BEAT  = BW'(BEATS - 1);
  localparam logic [7:0]        LINE_LEN   = 8'(BEATS - 1);
  localparam logic [2:0]        LINE_SIZE  = 3'($clog2(DATA_W / 8));
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_W / 8 - 1);

  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, RESP} state_t;

  state_t                state, state_nxt;
  logic                  write_q, dev_q;
  logic [ADDR_W-1:0]     addr_q, axi_addr;
  logic [2:0]            size_q;
  logic [LINE_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic [BW-1:0]         beat;
  logic                  accept;
  logic                  unused_ids;

  // Response IDs are deliberately ignored: only one transaction is ever outstanding.
  assign unused_ids = ^{axi_b_id_i, axi_r_id_i, write_q};

  assign accept   = req_valid && req_ready;
  assign axi_addr = dev_q ? addr_q : (addr_q & ALIGN_MASK);

  assign axi_ar_addr_o  = axi_addr;
  assign axi_ar_id_o    = AXI_ID;
  assign axi_ar_len_o   = dev_q ? 8'd0 : LINE_LEN;
  assign axi_ar_size_o  = dev_q ? size_q : LINE_SIZE;
  assign axi_ar_burst_o = 2'b01;
  assign axi_aw_addr_o  = axi_addr;
  assign axi_aw_id_o    = AXI_ID;
  assign axi_aw_len_o   = dev_q ? 8'd0 : LINE_LEN;
  assign axi_aw_size_o  = dev_q ? size_q : LINE_SIZE;
  assign axi_aw_burst_o = 2'b01;
  assign axi_w_data_o   = wdata_q[beat*DATA_W +: DATA_W];
  assign axi_w_strb_o   = dev_q ? wstrb_q : '1;
  assign axi_w_last_o   = dev_q || (beat == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    axi_ar_valid_o = 1'b0;
    axi_aw_valid_o = 1'b0;
    axi_w_valid_o  = 1'b0;
    axi_r_ready_o  = 1'b0;
    axi_b_ready_o  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_write ? AW : AR;
      end
      AR: begin
        axi_ar_valid_o = 1'b1;
        if (axi_ar_ready_i) state_nxt = R;
      end
      R: begin
        axi_r_ready_o = 1'b1;
        if (axi_r_valid_i && axi_r_last_i) state_nxt = RESP;
      end
      AW: begin
        axi_aw_valid_o = 1'b1;
        if (axi_aw_ready_i) state_nxt = W;
      end
      W: begin
        axi_w_valid_o = 1'b1;
        if (axi_w_ready_i && axi_w_last_o) state_nxt = B;
      end
      B: begin
        axi_b_ready_o = 1'b1;
        if (axi_b_valid_i) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_q    <= 1'b0;
      dev_q      <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      beat       <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        write_q    <= req_write;
        dev_q      <= req_dev;
        addr_q     <= req_addr;
        size_q     <= req_size;
        wdata_q    <= req_wdata;
        wstrb_q    <= req_wstrb;
        beat       <= '0;
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
      if (state == R && axi_r_valid_i) begin
        if (dev_q) resp_rdata <= LINE_W'(axi_r_data_i);
        else       resp_rdata[beat*DATA_W +: DATA_W] <= axi_r_data_i;
        if (axi_r_resp_i != 2'b00) resp_err <= 1'b1;
        // A short burst leaves part of the line unfilled, so it is reported as an error.
        if (axi_r_last_i && !dev_q && beat != LAST_BEAT) resp_err <= 1'b1;
        if (beat != LAST_BEAT) beat <= beat + 1'b1;
      end
      if (state == W && axi_w_ready_i) begin
        if (axi_w_last_o)            beat <= '0;
        else if (beat != LAST_BEAT)  beat <= beat + 1'b1;
      end
      if (state == B && axi_b_valid_i && axi_b_resp_i != 2'b00) resp_err <= 1'b1;
    end
  end

endmodule
